// File: rtl/seq_detect_param.sv
// Run-time loadable serial bit-sequence detector with overlapping/non-overlapping modes.
// Optional saturating match counter, built when SEQ_DETECT_MATCH_CNT_EN is defined.
module seq_detect_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 DEF_LEN     = 5,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(5'b10010),
    parameter int                 CNT_W       = 8,
    localparam int                LW          = $clog2(MAX_LEN + 1)
) (
    input  logic               CLOCK_50,
    input  logic               rst,
    input  logic               x,
    input  logic               x_valid,
    input  logic               overlap,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    output logic               match,
    output logic               z,
    output logic               cfg_err,
    output logic [LW-1:0]      fill,
    output logic [CNT_W-1:0]   match_cnt
);

    logic [MAX_LEN-1:0] history_reg;
    logic [MAX_LEN-1:0] pattern_reg;
    logic [LW-1:0]      len_reg;
    logic [LW-1:0]      fill_reg;
    logic               match_reg;
    logic               cfg_err_reg;

    logic [MAX_LEN-1:0] history_next;
    logic [LW-1:0]      fill_next;
    logic [MAX_LEN-1:0] len_mask;
    logic               hit;
    logic               cfg_legal;

    // Only the low len bits of history and pattern take part in the compare.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
        assign len_mask[gi] = (LW'(gi) < len_reg);
    end

    assign history_next = {history_reg[MAX_LEN-2:0], x};
    assign fill_next    = (fill_reg == LW'(MAX_LEN)) ? fill_reg : fill_reg + LW'(1);
    assign hit          = (((history_next ^ pattern_reg) & len_mask) == '0)
                          && (fill_next >= len_reg);
    assign cfg_legal    = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            history_reg <= '0;
            fill_reg    <= '0;
            pattern_reg <= DEF_PATTERN;
            len_reg     <= LW'(DEF_LEN);
            match_reg   <= 1'b0;
            cfg_err_reg <= 1'b0;
        end else begin
            match_reg   <= 1'b0;
            cfg_err_reg <= 1'b0;
            if (cfg_load) begin
                // A load always swallows the bit presented in the same cycle.
                if (cfg_legal) begin
                    pattern_reg <= cfg_pattern;
                    len_reg     <= cfg_len;
                    history_reg <= '0;
                    fill_reg    <= '0;
                end else begin
                    cfg_err_reg <= 1'b1;
                end
            end else if (x_valid) begin
                history_reg <= history_next;
                fill_reg    <= (hit && !overlap) ? '0 : fill_next;
                match_reg   <= hit;
            end
        end
    end

    assign match   = match_reg;
    assign z       = ~match_reg;
    assign cfg_err = cfg_err_reg;
    assign fill    = fill_reg;

`ifdef SEQ_DETECT_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (!cfg_load && x_valid && hit && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign match_cnt = cnt_reg;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: expected outputs are queued per driven cycle
// from a behavioural model and checked one cycle later.
module tb_seq_detect_param;

    localparam int MAX_LEN = 8;
    localparam int LW      = 4;
    localparam int CNT_W   = 2;

    logic             CLOCK_50 = 1'b0;
    logic             rst = 1'b0;
    logic             x = 1'b0;
    logic             x_valid = 1'b0;
    logic             overlap = 1'b0;
    logic             cfg_load = 1'b0;
    logic [7:0]       cfg_pattern = '0;
    logic [LW-1:0]    cfg_len = '0;
    logic             match;
    logic             z;
    logic             cfg_err;
    logic [LW-1:0]    fill;
    logic [CNT_W-1:0] match_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       match;
        logic       err;
        logic [3:0] fill;
        logic [1:0] cnt;
    } exp_t;

    exp_t sb[$];

    int m_hist, m_fill, m_pat, m_len, m_cnt;

    always #10 CLOCK_50 = ~CLOCK_50;

    seq_detect_param #(
        .MAX_LEN(MAX_LEN),
        .DEF_LEN(5),
        .CNT_W  (CNT_W)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .rst        (rst),
        .x          (x),
        .x_valid    (x_valid),
        .overlap    (overlap),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .match      (match),
        .z          (z),
        .cfg_err    (cfg_err),
        .fill       (fill),
        .match_cnt  (match_cnt)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic xv, input logic xi, input logic ov,
                       input logic ld, input logic [7:0] pat, input logic [3:0] ln);
        exp_t e;
        int   msk;
        bit   h;
        rst = r; x_valid = xv; x = xi; overlap = ov;
        cfg_load = ld; cfg_pattern = pat; cfg_len = ln;
        e.match = 1'b0;
        e.err   = 1'b0;
        if (r) begin
            m_hist = 0; m_fill = 0; m_pat = 'b10010; m_len = 5; m_cnt = 0;
        end else if (ld) begin
            if (ln >= 1 && ln <= MAX_LEN) begin
                m_pat = int'(pat); m_len = int'(ln); m_hist = 0; m_fill = 0;
            end else begin
                e.err = 1'b1;
            end
        end else if (xv) begin
            m_hist = ((m_hist << 1) | int'(xi)) & 255;
            m_fill = (m_fill < MAX_LEN) ? m_fill + 1 : MAX_LEN;
            msk    = (1 << m_len) - 1;
            h      = ((m_hist & msk) == (m_pat & msk)) && (m_fill >= m_len);
            e.match = h;
            if (h && !ov) m_fill = 0;
            if (h && m_cnt < 3) m_cnt++;
        end
        e.fill = 4'(m_fill);
`ifdef SEQ_DETECT_MATCH_CNT_EN
        e.cnt = 2'(m_cnt);
`else
        e.cnt = 2'd0;
`endif
        sb.push_back(e);
        @(posedge CLOCK_50);
        #1;
        e = sb.pop_front();
        chk("match", {7'd0, match}, {7'd0, e.match});
        chk("z", {7'd0, z}, {7'd0, ~e.match});
        chk("cfg_err", {7'd0, cfg_err}, {7'd0, e.err});
        chk("fill", {4'd0, fill}, {4'd0, e.fill});
        chk("match_cnt", {6'd0, match_cnt}, {6'd0, e.cnt});
        $display("t=%0t rst=%0b ld=%0b xv=%0b x=%0b ov=%0b -> match=%0b z=%0b err=%0b fill=%0d cnt=%0d",
                 $time, r, ld, xv, xi, ov, match, z, cfg_err, fill, match_cnt);
    endtask

    initial begin
        logic [7:0] s1;
        logic [6:0] s2;
        s1 = 8'b10010010;
        s2 = 7'b1011011;

        // Reset held two cycles while x toggles
        cyc(1, 1, 1, 1, 0, 8'h00, 4'd0);
        cyc(1, 1, 0, 1, 0, 8'h00, 4'd0);

        // Default pattern, overlapping: hits after bits 5 and 8
        for (int i = 7; i >= 0; i--) cyc(0, 1, s1[i], 1, 0, 8'h00, 4'd0);
        cyc(0, 0, 1, 1, 0, 8'h00, 4'd0);
        cyc(0, 0, 0, 1, 0, 8'h00, 4'd0);

        // Reload default pattern to clear history, then non-overlapping
        cyc(0, 0, 0, 0, 1, 8'b10010, 4'd5);
        for (int i = 7; i >= 0; i--) cyc(0, 1, s1[i], 0, 0, 8'h00, 4'd0);

        // Load together with a valid bit: bit discarded
        cyc(0, 1, 1, 1, 1, 8'b1011, 4'd4);
        for (int i = 6; i >= 0; i--) cyc(0, 1, s2[i], 1, 0, 8'h00, 4'd0);

        // Illegal loads leave configuration and fill alone
        cyc(0, 1, 1, 1, 1, 8'hFF, 4'd0);
        cyc(0, 1, 0, 1, 1, 8'hFF, 4'd9);
        cyc(0, 1, 0, 1, 0, 8'h00, 4'd0);
        cyc(0, 1, 1, 1, 0, 8'h00, 4'd0);
        cyc(0, 1, 1, 1, 0, 8'h00, 4'd0);

        // Length 1, counter saturation
        cyc(1, 0, 0, 1, 0, 8'h00, 4'd0);
        cyc(0, 0, 0, 1, 1, 8'hFE, 4'd1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 0, 8'h00, 4'd0);
        cyc(0, 0, 0, 1, 1, 8'hF1, 4'd1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1, 0, 8'h00, 4'd0);

        // Random traffic with occasional legal reconfiguration
        cyc(0, 0, 0, 1, 1, 8'b011, 4'd3);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 15) == 0)
                cyc(0, 1, 1'($urandom), 1'($urandom), 1, 8'($urandom), 4'($urandom_range(1, 8)));
            else
                cyc(0, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 0, 8'h00, 4'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
